rv64_zba_core: RTL and testbench
================================

# rv64_zba_core

Five-stage in-order RV64I pipeline with Zba address-generation extensions; this is the top-level processor block. It contains the fetch stage with its 1024-word instruction ROM, plus decode, execute, memory and writeback stages, the register file and a private data RAM. Software is preloaded into the ROM by hierarchical access. The only pins are clock and reset; PC_F, Instr_D and Result_W are exposed as internal top-level signals for observation.

## Interface
- No parameters. Fixed: XLEN 64; IMEM 1024×32; DMEM 1024×64.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears PC and all pipeline registers.
- Required internal names at top level:
  - PC_F (64): fetch PC.
  - Instr_D (32): decode-stage instruction.
  - Result_W (64): writeback value.
  - Fetch instance IF_STAGE, containing instance imem, containing array rom [0:1023] of 32-bit words.

## Operation
- Stages: F, D, E, M, W, separated by pipeline registers. Each register carries a valid bit.
- Fetch:
  - Instruction = rom[PC_F[11:2]]. Higher PC bits are ignored, so addresses wrap modulo 4 KiB.
  - Next PC = PC_F+4, unless a taken branch or jump in E redirects it.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LD, LW (sign-extended), SD, SW.
  - OP-IMM: ADDI, SLTI(U), XORI, ORI, ANDI, SLLI/SRLI/SRAI with 6-bit shamt.
  - OP: ADD, SUB, SLL, SLT(U), XOR, SRL, SRA, OR, AND.
  - ADDIW, ADDW, SUBW: 32-bit result, sign-extended to 64.
  - Zba: SH1ADD/SH2ADD/SH3ADD = (rs1<<1/2/3)+rs2, encoded as opcode 0110011, funct7 0010000, funct3 010/100/110.
  - Any other encoding executes as a NOP: no register write, no memory write.
- Register file:
  - 32×64; x0 reads 0 and is never written.
  - Written in W. A read in D of a register being written in W the same cycle returns the new value (write-through).
- Forwarding into E operands: M-stage ALU result has priority over W-stage result, then the register file value. No forwarding from a zero destination register.
- Load-use hazard:
  - Triggered when the instruction in E is a load and the D instruction reads its rd (rd≠0).
  - Stall F and D for 1 cycle; insert a bubble into E.
- Control flow:
  - Branches and jumps resolve in E. On taken: redirect PC, flush D and E (2-cycle penalty). Not-taken costs nothing.
  - JAL/JALR write PC+4. JALR target = (rs1+imm)&~1.
- Data RAM:
  - Indexed by addr[12:3]. SW writes the 32-bit half selected by addr[2].
  - Misaligned accesses are not detected.
  - Contents are zero at time 0 and are not affected by reset.
- Result_W = load data for loads, PC+4 for jumps, ALU result otherwise. It is 0 for bubbles and invalid slots.

## Timing
- Reset asserted:
  - PC_F=0, Instr_D=0x00000013 (NOP), Result_W=0, all valid bits 0.
  - Register file cleared to 0. ROM is untouched.
- First rising edge after release: fetches address 0.
- An instruction fetched at edge n:
  - is in Instr_D after edge n+1;
  - its Result_W is visible after edge n+4;
  - it is written to the register file at edge n+5.
- Throughput is 1 instruction per cycle, except load-use stalls (+1) and taken control flow (+2).
- Stall and flush in the same cycle: flush wins.
- Reset mid-run: abandons all in-flight instructions immediately; no partial register or memory writes after assertion.

## Test plan
- Zba with forwarding:
  - Program: addi x1,x0,0x10; addi x2,x0,8; sh1add x3,x1,x2.
  - Required: Result_W shows 0x10, 0x08, 0x28 on consecutive cycles. The first is visible 4 cycles after its fetch.
- Zba sweep:
  - x1=3, x2=5. sh2add yields 0x11; sh3add yields 0x1D.
  - Subw 0-1 yields 0xFFFFFFFFFFFFFFFF.
- Load-use:
  - Program: sd x3,0(x0); ld x4,0(x0); add x5,x4,x4.
  - Required: x5=0x50, exactly one bubble (Result_W=0) between ld and add.
- Taken branch:
  - Program: beq x0,x0,+12 followed by two addi x6.
  - Required: both addi are flushed, x6 stays 0, and PC_F jumps to target after 2 wasted slots.
- JAL/JALR loop:
  - Program: jal x1,+8 at PC 0x20.
  - Required: Result_W=0x24. jalr x0,0(x1) returns to 0x24.
- Reset mid-run:
  - Assert rst during execution.
  - Required: PC_F=0 and Result_W=0 immediately. After release, the program re-runs from address 0 with the same results.

Source files
------------

// File: rtl/rv64_zba_core.sv
// rtl/rv64_zba_core.sv - five-stage in-order RV64I+Zba pipeline with private ROM and data RAM
// Branches resolve in E; operands forward M-then-W; loads stall one cycle on use.
module rv64_zba_imem (
  input  logic [9:0]  addr_i,
  output logic [31:0] instr_o
);
  logic [31:0] rom [0:1023];
  assign instr_o = rom[addr_i];
endmodule

module rv64_zba_fetch (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] target_i,
  output logic [63:0] pc_o,
  output logic [31:0] instr_o
);
  logic [63:0] pc_q, pc_d;

  rv64_zba_imem imem (.addr_i(pc_q[11:2]), .instr_o(instr_o));

  always_comb begin
    pc_d = pc_q + 64'd4;
    if (redirect_i)   pc_d = target_i;
    else if (stall_i) pc_d = pc_q;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pc_q <= '0;
    else       pc_q <= pc_d;

  assign pc_o = pc_q;
endmodule

module rv64_zba_core (
  input logic clk,
  input logic rst
);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA,
    A_OR, A_AND, A_SH1, A_SH2, A_SH3, A_PASSB
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic use_imm, use_pc, word, reg_write, mem_read, mem_write, mem_word;
    logic branch, jal, jalr, uses_rs1, uses_rs2;
  } ctrl_t;

  logic [63:0] PC_F, Result_W;
  logic [31:0] Instr_D, fetch_instr;
  logic        stall, flush;
  logic [63:0] target;

  rv64_zba_fetch IF_STAGE (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(flush),
    .target_i(target), .pc_o(PC_F), .instr_o(fetch_instr)
  );

  logic        d_valid_q;
  logic [63:0] d_pc_q;
  logic        e_valid_q, m_valid_q, w_valid_q;
  ctrl_t       d_ctrl, e_ctrl_q;
  logic [63:0] d_imm, e_imm_q, e_pc_q, e_a_q, e_b_q;
  logic [4:0]  e_rs1_q, e_rs2_q, e_rd_q, m_rd_q, w_rd_q;
  logic [2:0]  e_f3_q;
  logic        m_reg_write_q, m_mem_read_q, m_mem_write_q, m_mem_word_q, w_reg_write_q;
  logic [63:0] m_result_q, m_store_q, w_result_q;
  logic [63:0] rf_q [0:31];
  logic [63:0] dmem_q [0:1023];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d_valid_q <= 1'b0; d_pc_q <= '0; Instr_D <= NOP;
    end else if (flush) begin
      d_valid_q <= 1'b0; Instr_D <= NOP;
    end else if (!stall) begin
      d_valid_q <= 1'b1; d_pc_q <= PC_F; Instr_D <= fetch_instr;
    end

  logic [4:0]  d_rs1, d_rs2;
  logic [2:0]  d_f3;
  logic [6:0]  d_f7;
  logic [63:0] d_rs1_val, d_rs2_val;
  logic        w_we;
  assign d_rs1 = Instr_D[19:15];
  assign d_rs2 = Instr_D[24:20];
  assign d_f3  = Instr_D[14:12];
  assign d_f7  = Instr_D[31:25];
  assign w_we  = w_valid_q & w_reg_write_q & (w_rd_q != 5'd0);

  always_comb begin
    d_ctrl = '0;
    d_imm  = {{52{Instr_D[31]}}, Instr_D[31:20]};
    case (Instr_D[6:0])
      7'b0110111: begin
        d_ctrl.op = A_PASSB; d_ctrl.use_imm = 1'b1; d_ctrl.reg_write = 1'b1;
        d_imm = {{32{Instr_D[31]}}, Instr_D[31:12], 12'b0};
      end
      7'b0010111: begin
        d_ctrl.use_pc = 1'b1; d_ctrl.use_imm = 1'b1; d_ctrl.reg_write = 1'b1;
        d_imm = {{32{Instr_D[31]}}, Instr_D[31:12], 12'b0};
      end
      7'b1101111: begin
        d_ctrl.jal = 1'b1; d_ctrl.reg_write = 1'b1;
        d_imm = {{43{Instr_D[31]}}, Instr_D[31], Instr_D[19:12], Instr_D[20], Instr_D[30:21], 1'b0};
      end
      7'b1100111: if (d_f3 == 3'b000) begin
        d_ctrl.jalr = 1'b1; d_ctrl.reg_write = 1'b1; d_ctrl.uses_rs1 = 1'b1;
      end
      7'b1100011: if (d_f3 != 3'b010 && d_f3 != 3'b011) begin
        d_ctrl.branch = 1'b1; d_ctrl.uses_rs1 = 1'b1; d_ctrl.uses_rs2 = 1'b1;
        d_imm = {{51{Instr_D[31]}}, Instr_D[31], Instr_D[7], Instr_D[30:25], Instr_D[11:8], 1'b0};
      end
      7'b0000011: if (d_f3 == 3'b011 || d_f3 == 3'b010) begin
        d_ctrl.mem_read = 1'b1; d_ctrl.reg_write = 1'b1; d_ctrl.use_imm = 1'b1;
        d_ctrl.uses_rs1 = 1'b1; d_ctrl.mem_word = (d_f3 == 3'b010);
      end
      7'b0100011: if (d_f3 == 3'b011 || d_f3 == 3'b010) begin
        d_ctrl.mem_write = 1'b1; d_ctrl.use_imm = 1'b1; d_ctrl.uses_rs1 = 1'b1;
        d_ctrl.uses_rs2 = 1'b1; d_ctrl.mem_word = (d_f3 == 3'b010);
        d_imm = {{52{Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
      end
      7'b0010011: begin
        d_ctrl.reg_write = 1'b1; d_ctrl.use_imm = 1'b1; d_ctrl.uses_rs1 = 1'b1;
        case (d_f3)
          3'b000:  d_ctrl.op = A_ADD;
          3'b001:  d_ctrl.op = A_SLL;
          3'b010:  d_ctrl.op = A_SLT;
          3'b011:  d_ctrl.op = A_SLTU;
          3'b100:  d_ctrl.op = A_XOR;
          3'b110:  d_ctrl.op = A_OR;
          3'b111:  d_ctrl.op = A_AND;
          default: d_ctrl.op = Instr_D[30] ? A_SRA : A_SRL;
        endcase
      end
      7'b0110011: begin
        d_ctrl.reg_write = 1'b1; d_ctrl.uses_rs1 = 1'b1; d_ctrl.uses_rs2 = 1'b1;
        case ({d_f7, d_f3})
          {7'h00, 3'b000}: d_ctrl.op = A_ADD;
          {7'h20, 3'b000}: d_ctrl.op = A_SUB;
          {7'h00, 3'b001}: d_ctrl.op = A_SLL;
          {7'h00, 3'b010}: d_ctrl.op = A_SLT;
          {7'h00, 3'b011}: d_ctrl.op = A_SLTU;
          {7'h00, 3'b100}: d_ctrl.op = A_XOR;
          {7'h00, 3'b101}: d_ctrl.op = A_SRL;
          {7'h20, 3'b101}: d_ctrl.op = A_SRA;
          {7'h00, 3'b110}: d_ctrl.op = A_OR;
          {7'h00, 3'b111}: d_ctrl.op = A_AND;
          {7'h10, 3'b010}: d_ctrl.op = A_SH1;
          {7'h10, 3'b100}: d_ctrl.op = A_SH2;
          {7'h10, 3'b110}: d_ctrl.op = A_SH3;
          default:         d_ctrl = '0;
        endcase
      end
      7'b0011011: if (d_f3 == 3'b000) begin
        d_ctrl.reg_write = 1'b1; d_ctrl.use_imm = 1'b1; d_ctrl.uses_rs1 = 1'b1; d_ctrl.word = 1'b1;
      end
      7'b0111011: if (d_f3 == 3'b000 && (d_f7 == 7'h00 || d_f7 == 7'h20)) begin
        d_ctrl.reg_write = 1'b1; d_ctrl.uses_rs1 = 1'b1; d_ctrl.uses_rs2 = 1'b1; d_ctrl.word = 1'b1;
        d_ctrl.op = (d_f7 == 7'h20) ? A_SUB : A_ADD;
      end
      default: d_ctrl = '0;
    endcase
    if (!d_valid_q) d_ctrl = '0;
  end

  // Write-through: D sees the value W commits at the same edge.
  assign d_rs1_val = (d_rs1 == 5'd0) ? '0 : (w_we && w_rd_q == d_rs1) ? w_result_q : rf_q[d_rs1];
  assign d_rs2_val = (d_rs2 == 5'd0) ? '0 : (w_we && w_rd_q == d_rs2) ? w_result_q : rf_q[d_rs2];

  assign stall = e_valid_q & e_ctrl_q.mem_read & (e_rd_q != 5'd0) &
                 ((d_ctrl.uses_rs1 & (d_rs1 == e_rd_q)) | (d_ctrl.uses_rs2 & (d_rs2 == e_rd_q)));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      e_valid_q <= 1'b0; e_ctrl_q <= '0; e_pc_q <= '0; e_imm_q <= '0; e_a_q <= '0; e_b_q <= '0;
      e_rs1_q <= '0; e_rs2_q <= '0; e_rd_q <= '0; e_f3_q <= '0;
    end else if (flush || stall) begin
      e_valid_q <= 1'b0; e_ctrl_q <= '0;
    end else begin
      e_valid_q <= d_valid_q; e_ctrl_q <= d_ctrl; e_pc_q <= d_pc_q; e_imm_q <= d_imm;
      e_a_q <= d_rs1_val; e_b_q <= d_rs2_val; e_rs1_q <= d_rs1; e_rs2_q <= d_rs2;
      e_rd_q <= Instr_D[11:7]; e_f3_q <= d_f3;
    end

  logic [63:0] fa, fb, alu_a, alu_b, alu_raw, e_alu, e_result;
  logic        m_fwd_ok, taken;
  assign m_fwd_ok = m_valid_q & m_reg_write_q & (m_rd_q != 5'd0);

  always_comb begin
    fa = e_a_q;
    if (e_ctrl_q.uses_rs1 && m_fwd_ok && m_rd_q == e_rs1_q)  fa = m_result_q;
    else if (e_ctrl_q.uses_rs1 && w_we && w_rd_q == e_rs1_q) fa = w_result_q;
    fb = e_b_q;
    if (e_ctrl_q.uses_rs2 && m_fwd_ok && m_rd_q == e_rs2_q)  fb = m_result_q;
    else if (e_ctrl_q.uses_rs2 && w_we && w_rd_q == e_rs2_q) fb = w_result_q;
  end

  assign alu_a = e_ctrl_q.use_pc  ? e_pc_q  : fa;
  assign alu_b = e_ctrl_q.use_imm ? e_imm_q : fb;

  always_comb begin
    alu_raw = '0;
    case (e_ctrl_q.op)
      A_ADD:   alu_raw = alu_a + alu_b;
      A_SUB:   alu_raw = alu_a - alu_b;
      A_SLL:   alu_raw = alu_a << alu_b[5:0];
      A_SLT:   alu_raw = {63'd0, $signed(alu_a) < $signed(alu_b)};
      A_SLTU:  alu_raw = {63'd0, alu_a < alu_b};
      A_XOR:   alu_raw = alu_a ^ alu_b;
      A_SRL:   alu_raw = alu_a >> alu_b[5:0];
      A_SRA:   alu_raw = $signed(alu_a) >>> alu_b[5:0];
      A_OR:    alu_raw = alu_a | alu_b;
      A_AND:   alu_raw = alu_a & alu_b;
      A_SH1:   alu_raw = (alu_a << 1) + alu_b;
      A_SH2:   alu_raw = (alu_a << 2) + alu_b;
      A_SH3:   alu_raw = (alu_a << 3) + alu_b;
      A_PASSB: alu_raw = alu_b;
      default: alu_raw = '0;
    endcase
  end

  assign e_alu    = e_ctrl_q.word ? {{32{alu_raw[31]}}, alu_raw[31:0]} : alu_raw;
  assign e_result = (e_ctrl_q.jal || e_ctrl_q.jalr) ? e_pc_q + 64'd4 : e_alu;

  always_comb begin
    case (e_f3_q)
      3'b000:  taken = (fa == fb);
      3'b001:  taken = (fa != fb);
      3'b100:  taken = ($signed(fa) <  $signed(fb));
      3'b101:  taken = ($signed(fa) >= $signed(fb));
      3'b110:  taken = (fa <  fb);
      3'b111:  taken = (fa >= fb);
      default: taken = 1'b0;
    endcase
  end

  assign flush  = e_valid_q & (e_ctrl_q.jal | e_ctrl_q.jalr | (e_ctrl_q.branch & taken));
  assign target = e_ctrl_q.jalr ? ((fa + e_imm_q) & ~64'd1) : e_pc_q + e_imm_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_valid_q <= 1'b0; m_reg_write_q <= 1'b0; m_mem_read_q <= 1'b0; m_mem_write_q <= 1'b0;
      m_mem_word_q <= 1'b0; m_rd_q <= '0; m_result_q <= '0; m_store_q <= '0;
    end else begin
      m_valid_q <= e_valid_q; m_reg_write_q <= e_ctrl_q.reg_write; m_mem_read_q <= e_ctrl_q.mem_read;
      m_mem_write_q <= e_ctrl_q.mem_write; m_mem_word_q <= e_ctrl_q.mem_word;
      m_rd_q <= e_rd_q; m_result_q <= e_result; m_store_q <= fb;
    end

  logic [9:0]  m_idx;
  logic [63:0] m_rdata, m_load;
  logic [31:0] m_half;
  assign m_idx   = m_result_q[12:3];
  assign m_rdata = dmem_q[m_idx];
  assign m_half  = m_result_q[2] ? m_rdata[63:32] : m_rdata[31:0];
  assign m_load  = m_mem_word_q ? {{32{m_half[31]}}, m_half} : m_rdata;

  // Data RAM is deliberately outside reset; rst only blocks a write in flight.
  always_ff @(posedge clk)
    if (!rst && m_valid_q && m_mem_write_q) begin
      if (!m_mem_word_q)       dmem_q[m_idx]        <= m_store_q;
      else if (m_result_q[2])  dmem_q[m_idx][63:32] <= m_store_q[31:0];
      else                     dmem_q[m_idx][31:0]  <= m_store_q[31:0];
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_valid_q <= 1'b0; w_reg_write_q <= 1'b0; w_rd_q <= '0; w_result_q <= '0;
    end else begin
      w_valid_q <= m_valid_q; w_reg_write_q <= m_reg_write_q; w_rd_q <= m_rd_q;
      w_result_q <= !m_valid_q ? '0 : m_mem_read_q ? m_load : m_result_q;
    end

  assign Result_W = w_result_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (w_we) begin
      rf_q[w_rd_q] <= w_result_q;
    end
endmodule

// File: tb/tb_rv64_zba_core.sv
// tb/tb_rv64_zba_core.sv - directed program checks of the rv64_zba_core pipeline
module tb_rv64_zba_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  rv64_zba_core dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic clear_rom;
    for (int i = 0; i < 1024; i++) dut.IF_STAGE.imem.rom[i] = 32'h00000013;
  endtask

  task automatic put(input int addr, input logic [31:0] w);
    dut.IF_STAGE.imem.rom[addr >> 2] = w;
  endtask

  task automatic hold_reset;
    @(negedge clk); rst = 1'b1; @(negedge clk);
  endtask

  task automatic start;
    @(negedge clk); rst = 1'b0; cyc = 0;
  endtask

  // Observation happens at the falling edge after rising edge number e since release.
  task automatic run_to(input int e);
    while (cyc < e) begin @(posedge clk); @(negedge clk); cyc++; end
  endtask

  task automatic load_fwd_prog;
    clear_rom();
    put(0, 32'h01000093);  // addi x1,x0,0x10
    put(4, 32'h00800113);  // addi x2,x0,8
    put(8, 32'h2020A1B3);  // sh1add x3,x1,x2
  endtask

  task automatic test_reset;
    load_fwd_prog();
    @(negedge clk); @(negedge clk);
    checks++; if (dut.PC_F !== 64'd0) begin errors++; $display("FAIL reset_pc got %h want 0", dut.PC_F); end
    checks++; if (dut.Instr_D !== 32'h00000013) begin errors++; $display("FAIL reset_instr got %h want 00000013", dut.Instr_D); end
    checks++; if (dut.Result_W !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", dut.Result_W); end
    checks++; if (dut.rf_q[1] !== 64'd0) begin errors++; $display("FAIL reset_x1 got %h want 0", dut.rf_q[1]); end
  endtask

  task automatic test_zba_fwd;
    logic [63:0] exp [3];
    exp[0] = 64'h10; exp[1] = 64'h08; exp[2] = 64'h28;
    hold_reset(); load_fwd_prog(); start();
    run_to(1);
    checks++; if (dut.Instr_D !== 32'h01000093) begin errors++; $display("FAIL fwd_instr_d got %h want 01000093", dut.Instr_D); end
    checks++; if (dut.PC_F !== 64'd4) begin errors++; $display("FAIL fwd_pc1 got %h want 4", dut.PC_F); end
    run_to(3);
    checks++; if (dut.Result_W !== 64'd0) begin errors++; $display("FAIL fwd_early got %h want 0", dut.Result_W); end
    for (int i = 0; i < 3; i++) begin
      run_to(4 + i);
      checks++;
      if (dut.Result_W !== exp[i]) begin errors++; $display("FAIL fwd_result%0d got %h want %h", i, dut.Result_W, exp[i]); end
    end
    run_to(8);
    checks++; if (dut.rf_q[3] !== 64'h28) begin errors++; $display("FAIL fwd_x3 got %h want 28", dut.rf_q[3]); end
  endtask

  task automatic test_zba_sweep;
    logic [63:0] exp [6];
    exp[0] = 64'h3; exp[1] = 64'h5; exp[2] = 64'h11; exp[3] = 64'h1D; exp[4] = 64'h1;
    exp[5] = 64'hFFFF_FFFF_FFFF_FFFF;
    hold_reset(); clear_rom();
    put(0,  32'h00300093);  // addi x1,x0,3
    put(4,  32'h00500113);  // addi x2,x0,5
    put(8,  32'h2020C1B3);  // sh2add x3,x1,x2
    put(12, 32'h2020E233);  // sh3add x4,x1,x2
    put(16, 32'h00100293);  // addi x5,x0,1
    put(20, 32'h4050033B);  // subw x6,x0,x5
    start();
    for (int i = 0; i < 6; i++) begin
      run_to(4 + i);
      checks++;
      if (dut.Result_W !== exp[i]) begin errors++; $display("FAIL sweep_result%0d got %h want %h", i, dut.Result_W, exp[i]); end
    end
  endtask

  task automatic test_load_use;
    hold_reset(); clear_rom();
    put(0,  32'h02800193);  // addi x3,x0,0x28
    put(4,  32'h00303023);  // sd x3,0(x0)
    put(8,  32'h00003203);  // ld x4,0(x0)
    put(12, 32'h004202B3);  // add x5,x4,x4
    start();
    run_to(5);
    checks++; if (dut.PC_F !== 64'd16) begin errors++; $display("FAIL lu_pc_hold got %h want 10", dut.PC_F); end
    checks++; if (dut.Instr_D !== 32'h004202B3) begin errors++; $display("FAIL lu_instr_hold got %h want 004202b3", dut.Instr_D); end
    run_to(6);
    checks++; if (dut.Result_W !== 64'h28) begin errors++; $display("FAIL lu_ld_result got %h want 28", dut.Result_W); end
    run_to(7);
    checks++; if (dut.Result_W !== 64'd0) begin errors++; $display("FAIL lu_bubble got %h want 0", dut.Result_W); end
    run_to(8);
    checks++; if (dut.Result_W !== 64'h50) begin errors++; $display("FAIL lu_add_result got %h want 50", dut.Result_W); end
    run_to(10);
    checks++; if (dut.rf_q[5] !== 64'h50) begin errors++; $display("FAIL lu_x5 got %h want 50", dut.rf_q[5]); end
  endtask

  task automatic test_branch;
    hold_reset(); clear_rom();
    put(0,  32'h00000663);  // beq x0,x0,+12
    put(4,  32'h00100313);  // addi x6,x0,1
    put(8,  32'h00100313);  // addi x6,x0,1
    put(12, 32'h00700393);  // addi x7,x0,7
    start();
    run_to(2);
    checks++; if (dut.PC_F !== 64'd8) begin errors++; $display("FAIL br_pc2 got %h want 8", dut.PC_F); end
    run_to(3);
    checks++; if (dut.PC_F !== 64'd12) begin errors++; $display("FAIL br_target got %h want c", dut.PC_F); end
    run_to(5);
    checks++; if (dut.Result_W !== 64'd0) begin errors++; $display("FAIL br_flush1 got %h want 0", dut.Result_W); end
    run_to(6);
    checks++; if (dut.Result_W !== 64'd0) begin errors++; $display("FAIL br_flush2 got %h want 0", dut.Result_W); end
    run_to(7);
    checks++; if (dut.Result_W !== 64'd7) begin errors++; $display("FAIL br_target_result got %h want 7", dut.Result_W); end
    run_to(10);
    checks++; if (dut.rf_q[6] !== 64'd0) begin errors++; $display("FAIL br_x6 got %h want 0", dut.rf_q[6]); end
  endtask

  task automatic test_jal_loop;
    hold_reset(); clear_rom();
    put(32'h20, 32'h008000EF);  // jal x1,+8
    put(32'h24, 32'h00900493);  // addi x9,x0,9
    put(32'h28, 32'h00008067);  // jalr x0,0(x1)
    start();
    run_to(11);
    checks++; if (dut.PC_F !== 64'h28) begin errors++; $display("FAIL jal_target got %h want 28", dut.PC_F); end
    run_to(12);
    checks++; if (dut.Result_W !== 64'h24) begin errors++; $display("FAIL jal_link got %h want 24", dut.Result_W); end
    run_to(13);
    checks++; if (dut.Result_W !== 64'd0) begin errors++; $display("FAIL jal_flush got %h want 0", dut.Result_W); end
    run_to(14);
    checks++; if (dut.PC_F !== 64'h24) begin errors++; $display("FAIL jalr_target got %h want 24", dut.PC_F); end
    checks++; if (dut.rf_q[1] !== 64'h24) begin errors++; $display("FAIL jal_x1 got %h want 24", dut.rf_q[1]); end
    run_to(15);
    checks++; if (dut.Result_W !== 64'h2C) begin errors++; $display("FAIL jalr_link got %h want 2c", dut.Result_W); end
    run_to(18);
    checks++; if (dut.Result_W !== 64'd9) begin errors++; $display("FAIL loop_body got %h want 9", dut.Result_W); end
    checks++; if (dut.PC_F !== 64'h24) begin errors++; $display("FAIL loop_pc got %h want 24", dut.PC_F); end
  endtask

  task automatic test_reset_midrun;
    logic [63:0] exp [3];
    exp[0] = 64'h10; exp[1] = 64'h08; exp[2] = 64'h28;
    hold_reset(); load_fwd_prog(); start();
    run_to(6);
    checks++; if (dut.rf_q[1] !== 64'h10) begin errors++; $display("FAIL mid_pre_x1 got %h want 10", dut.rf_q[1]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dut.PC_F !== 64'd0) begin errors++; $display("FAIL mid_pc got %h want 0", dut.PC_F); end
    checks++; if (dut.Result_W !== 64'd0) begin errors++; $display("FAIL mid_result got %h want 0", dut.Result_W); end
    checks++; if (dut.Instr_D !== 32'h00000013) begin errors++; $display("FAIL mid_instr got %h want 00000013", dut.Instr_D); end
    checks++; if (dut.rf_q[1] !== 64'd0) begin errors++; $display("FAIL mid_x1 got %h want 0", dut.rf_q[1]); end
    @(negedge clk);
    start();
    for (int i = 0; i < 3; i++) begin
      run_to(4 + i);
      checks++;
      if (dut.Result_W !== exp[i]) begin errors++; $display("FAIL mid_rerun%0d got %h want %h", i, dut.Result_W, exp[i]); end
    end
    run_to(8);
    checks++; if (dut.rf_q[3] !== 64'h28) begin errors++; $display("FAIL mid_x3 got %h want 28", dut.rf_q[3]); end
  endtask

  initial begin
    test_reset();
    test_zba_fwd();
    test_zba_sweep();
    test_load_use();
    test_branch();
    test_jal_loop();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
